// File: rtl/best_neighbor_scan.sv
// Read-only sequencer: reads neighborCount, scans the qValue table for the highest Q,
// then fetches the winning entry's neighborID from the shared word memory.
//
// state  | meaning
// IDLE   | waiting for start, mem_addr parked at 0
// RD_CNT | reading neighborCount, clamping to MAX_NBRS
// SCAN   | one qValue per cycle, tracking the strict maximum
// RD_ID  | reading neighborID of the winner
// DONE   | one-cycle done pulse
module best_neighbor_scan #(
  parameter logic [15:0] NBR_COUNT_ADDR = 16'h068A,
  parameter logic [15:0] QVALUE_BASE    = 16'h01C8,
  parameter logic [15:0] NBR_ID_BASE    = 16'h0048,
  parameter int          MAX_NBRS       = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] mem_addr,
  output logic        mem_wr_en,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [15:0] best_id,
  output logic [15:0] best_q,
  output logic [5:0]  best_idx
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RD_CNT = 3'd1;
  localparam logic [2:0] SCAN   = 3'd2;
  localparam logic [2:0] RD_ID  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [15:0] MAX_N16 = 16'(MAX_NBRS);
  localparam logic [6:0]  MAX_N7  = 7'(MAX_NBRS);

  logic [2:0] state;
  logic [6:0] n;
  logic [6:0] i;
  logic [6:0] n_clamped;

  assign mem_wr_en = 1'b0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign n_clamped = (mem_rdata > MAX_N16) ? MAX_N7 : mem_rdata[6:0];

  always_comb begin
    mem_addr = 16'h0000;
    case (state)
      RD_CNT:  mem_addr = NBR_COUNT_ADDR;
      SCAN:    mem_addr = QVALUE_BASE + {8'b0, i, 1'b0};
      RD_ID:   mem_addr = NBR_ID_BASE + {9'b0, best_idx, 1'b0};
      default: mem_addr = 16'h0000;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      n        <= 7'd0;
      i        <= 7'd0;
      found    <= 1'b0;
      best_id  <= 16'h0000;
      best_q   <= 16'h0000;
      best_idx <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RD_CNT;
            found    <= 1'b0;
            best_id  <= 16'h0000;
            best_q   <= 16'h0000;
            best_idx <= 6'd0;
          end
        end
        RD_CNT: begin
          n     <= n_clamped;
          i     <= 7'd0;
          state <= (n_clamped == 7'd0) ? DONE : SCAN;
        end
        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (i == 7'd0 || mem_rdata > best_q) begin
            best_q   <= mem_rdata;
            best_idx <= i[5:0];
          end
          if (i == n - 7'd1) state <= RD_ID;
          else               i     <= i + 7'd1;
        end
        RD_ID: begin
          best_id <= mem_rdata;
          found   <= 1'b1;
          state   <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_best_neighbor_scan.sv
// Directed bench for best_neighbor_scan with a byte-addressed combinational memory model.
module tb_best_neighbor_scan;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        found;
  logic [15:0] best_id;
  logic [15:0] best_q;
  logic [5:0]  best_idx;

  logic [7:0] mem [0:2047];

  int errors = 0;
  int checks = 0;

  int          done_cnt = 0;
  int          addr_nz  = 0;
  logic [15:0] last_nz  = 16'h0;
  logic [15:0] last_q_addr = 16'h0;

  best_neighbor_scan dut (
    .clock(clock), .reset(reset), .start(start),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .found(found),
    .best_id(best_id), .best_q(best_q), .best_idx(best_idx)
  );

  always #5 clock = ~clock;

  assign mem_rdata = {mem[mem_addr[10:0]], mem[mem_addr[10:0] + 11'd1]};

  always @(negedge clock) begin
    if (done) done_cnt++;
    if (mem_addr != 16'h0) begin
      addr_nz++;
      last_nz = mem_addr;
    end
    if (mem_addr >= 16'h01C8 && mem_addr <= 16'h0247) last_q_addr = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_word(input int addr, input logic [15:0] val);
    mem[addr]     = val[15:8];
    mem[addr + 1] = val[7:0];
  endtask

  task automatic set_q(input int idx, input logic [15:0] val);
    wr_word(16'h01C8 + 2 * idx, val);
  endtask

  task automatic set_id(input int idx, input logic [15:0] val);
    wr_word(16'h0048 + 2 * idx, val);
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Returns the cycle (counted from the start-sampling edge) in which done is seen; 0 on timeout.
  task automatic run(output int cyc);
    pulse_start();
    cyc = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clock);
      if (done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"},  {31'b0, busy}, 32'd0);
    check({tag, "_done"},  {31'b0, done}, 32'd0);
    check({tag, "_found"}, {31'b0, found}, 32'd0);
    check({tag, "_id"},    {16'b0, best_id}, 32'd0);
    check({tag, "_q"},     {16'b0, best_q}, 32'd0);
    check({tag, "_idx"},   {26'b0, best_idx}, 32'd0);
    check({tag, "_addr"},  {16'b0, mem_addr}, 32'd0);
    check({tag, "_wr"},    {31'b0, mem_wr_en}, 32'd0);
  endtask

  initial begin
    int cyc;
    int snap;
    int ndone;
    int dcyc;

    for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // count=2, q={5,7}
    wr_word(16'h068A, 16'd2);
    set_q(0, 16'd5);  set_q(1, 16'd7);
    set_id(0, 16'd30); set_id(1, 16'd31);
    run(cyc);
    check("t1_cycle", cyc, 32'd5);
    check("t1_busy_in_done", {31'b0, busy}, 32'd1);
    check("t1_found", {31'b0, found}, 32'd1);
    check("t1_id", {16'b0, best_id}, 32'd31);
    check("t1_q", {16'b0, best_q}, 32'd7);
    check("t1_idx", {26'b0, best_idx}, 32'd1);
    @(negedge clock);
    check("t1_busy_after", {31'b0, busy}, 32'd0);
    check("t1_done_after", {31'b0, done}, 32'd0);
    check("t1_hold_id", {16'b0, best_id}, 32'd31);

    // count=3, tie at the top keeps index 0
    wr_word(16'h068A, 16'd3);
    set_q(0, 16'd9); set_q(1, 16'd9); set_q(2, 16'd4);
    set_id(0, 16'd40); set_id(1, 16'd41); set_id(2, 16'd42);
    run(cyc);
    check("t2_cycle", cyc, 32'd6);
    check("t2_idx", {26'b0, best_idx}, 32'd0);
    check("t2_id", {16'b0, best_id}, 32'd40);
    check("t2_q", {16'b0, best_q}, 32'd9);

    // count=0
    wr_word(16'h068A, 16'd0);
    snap = addr_nz;
    run(cyc);
    check("t3_cycle", cyc, 32'd2);
    check("t3_found", {31'b0, found}, 32'd0);
    check("t3_id", {16'b0, best_id}, 32'd0);
    check("t3_q", {16'b0, best_q}, 32'd0);
    check("t3_addr_count", addr_nz - snap, 32'd1);
    check("t3_addr_value", {16'b0, last_nz}, 32'h068A);

    // count=100 clamps to 64
    wr_word(16'h068A, 16'd100);
    for (int k = 0; k < 63; k++) set_q(k, 16'(k));
    set_q(63, 16'hFFFF);
    for (int k = 0; k < 64; k++) set_id(k, 16'h0100 + 16'(k));
    run(cyc);
    check("t4_cycle", cyc, 32'd67);
    check("t4_last_q_addr", {16'b0, last_q_addr}, 32'h0246);
    check("t4_idx", {26'b0, best_idx}, 32'd63);
    check("t4_q", {16'b0, best_q}, 32'hFFFF);
    check("t4_id", {16'b0, best_id}, 32'h013F);

    // count=4, start pulsed during SCAN is ignored
    wr_word(16'h068A, 16'd4);
    set_q(0, 16'd3); set_q(1, 16'd8); set_q(2, 16'd2); set_q(3, 16'd6);
    set_id(0, 16'd50); set_id(1, 16'd51); set_id(2, 16'd52); set_id(3, 16'd53);
    pulse_start();
    ndone = 0;
    dcyc  = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (c == 3) start = 1'b1;
      if (c == 4) start = 1'b0;
      if (done) begin
        ndone++;
        dcyc = c;
      end
      if (c == 6) check("t5_busy_c6", {31'b0, busy}, 32'd1);
      if (c == 7) check("t5_busy_c7", {31'b0, busy}, 32'd1);
      if (c == 8) check("t5_busy_c8", {31'b0, busy}, 32'd0);
    end
    check("t5_done_count", ndone, 32'd1);
    check("t5_done_cycle", dcyc, 32'd7);
    check("t5_idx", {26'b0, best_idx}, 32'd1);
    check("t5_id", {16'b0, best_id}, 32'd51);

    // reset in the second SCAN cycle, then a clean rerun
    pulse_start();
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    check_zero_outputs("t6_rst");
    snap = done_cnt;
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("t6_no_done", done_cnt - snap, 32'd0);
    run(cyc);
    check("t6_cycle", cyc, 32'd7);
    check("t6_found", {31'b0, found}, 32'd1);
    check("t6_idx", {26'b0, best_idx}, 32'd1);
    check("t6_id", {16'b0, best_id}, 32'd51);
    check("t6_q", {16'b0, best_q}, 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
